// File: rtl/chunk_deserializer_if.sv
// chunk_deserializer_if
//   Bundles the chunk-serial input side and the word output side of
//   chunk_deserializer.
//   slave  : the deserializer's view (receives chunks, produces words).
//   master : the surrounding logic's view (sends chunks, consumes words).
//   Signals:
//     SIn/SInValid/SInReady   chunk stream, MS chunk first
//     Clear                   discard partially assembled word
//     POut/POutValid/POutAck  completed word with valid/ack handshake
//     Count                   chunks accepted toward current word
interface chunk_deserializer_if #(
   parameter int pwidth = 32,
   parameter int swidth = 8
);
   localparam int N  = pwidth / swidth;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [swidth-1:0] SIn;
   logic              SInValid;
   logic              SInReady;
   logic              Clear;
   logic [pwidth-1:0] POut;
   logic              POutValid;
   logic              POutAck;
   logic [CW-1:0]     Count;

   modport slave (
      input  SIn, SInValid, Clear, POutAck,
      output SInReady, POut, POutValid, Count
   );

   modport master (
      output SIn, SInValid, Clear, POutAck,
      input  SInReady, POut, POutValid, Count
   );
endinterface

// File: rtl/chunk_deserializer.sv
// chunk_deserializer
//   Collects swidth-bit chunks (most-significant chunk first) into
//   pwidth-bit words. A finished word sits in a register under a
//   valid/ack handshake; the only backpressure is on a completing chunk
//   that would overwrite a word nobody has taken yet.
//   Ports:
//     Clock  rising-edge system clock
//     Reset  synchronous, active-high; clears everything
//     bus    chunk_deserializer_if.slave (SIn/SInValid/SInReady, Clear,
//            POut/POutValid/POutAck, Count)
module chunk_deserializer #(
   parameter int pwidth = 32,
   parameter int swidth = 8
) (
   input  logic                    Clock,
   input  logic                    Reset,
   chunk_deserializer_if.slave     bus
);
   localparam int N     = pwidth / swidth;
   localparam int CW    = (N > 1) ? $clog2(N) : 1;
   localparam int ACC_W = (N > 1) ? (pwidth - swidth) : swidth;

   generate
      if ((pwidth % swidth) != 0 || N < 2) begin : g_cfg_err
         $error("chunk_deserializer: pwidth must be a multiple of swidth with pwidth/swidth >= 2");
      end
   endgenerate

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CW-1:0]     count_q, count_d;
   logic [pwidth-1:0] pout_q, pout_d;
   logic              pvalid_q, pvalid_d;

   logic last_chunk;
   logic ready;
   logic accept;
   logic complete;

   assign last_chunk = (count_q == CW'(N - 1));
   // Only a completing chunk can be stalled, and an ack this cycle frees
   // the output register, hence the combinational path from POutAck.
   assign ready      = !(last_chunk && pvalid_q && !bus.POutAck);
   assign accept     = bus.SInValid && ready && !bus.Clear;
   assign complete   = accept && last_chunk;

   always_comb begin
      acc_d    = acc_q;
      count_d  = count_q;
      pout_d   = pout_q;
      pvalid_d = pvalid_q;

      if (bus.Clear) begin
         acc_d   = '0;
         count_d = '0;
      end else if (accept) begin
         if (last_chunk) begin
            pout_d  = {acc_q, bus.SIn};
            count_d = '0;
         end else begin
            // Keeping the low ACC_W bits of {acc, SIn} shifts the new chunk
            // in at the bottom; also correct for N == 2 where acc is one chunk.
            acc_d   = ACC_W'({acc_q, bus.SIn});
            count_d = count_q + CW'(1);
         end
      end

      // A completion in the same cycle as an ack replaces the acked word.
      if (complete)
         pvalid_d = 1'b1;
      else if (bus.POutAck)
         pvalid_d = 1'b0;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         acc_q    <= '0;
         count_q  <= '0;
         pout_q   <= '0;
         pvalid_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         count_q  <= count_d;
         pout_q   <= pout_d;
         pvalid_q <= pvalid_d;
      end
   end

   assign bus.SInReady  = ready;
   assign bus.POut      = pout_q;
   assign bus.POutValid = pvalid_q;
   assign bus.Count     = count_q;
endmodule

// File: tb/tb_chunk_deserializer.sv
module tb_chunk_deserializer;
   localparam int PW = 32;
   localparam int SW = 8;
   localparam int N  = PW / SW;

   logic Clock;
   logic Reset;
   int   total = 0;
   int   bad   = 0;
   bit   cmp_en = 0;

   chunk_deserializer_if #(.pwidth(PW), .swidth(SW)) bus ();

   chunk_deserializer #(.pwidth(PW), .swidth(SW)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Holds the accepted chunks of the word in progress as a list; a word is
   // formed arithmetically once N chunks are present.
   int unsigned     m_chunks[$];
   logic [PW-1:0]   m_pout  = '0;
   bit              m_valid = 0;

   function automatic bit m_ready();
      return !((m_chunks.size() == N - 1) && m_valid && !bus.POutAck);
   endfunction

   always @(posedge Clock) begin
      if (Reset) begin
         m_chunks.delete();
         m_pout  = '0;
         m_valid = 0;
      end else begin
         bit done;
         done = 0;
         if (bus.Clear) begin
            m_chunks.delete();
         end else if (bus.SInValid && m_ready()) begin
            m_chunks.push_back(int'(bus.SIn));
            if (m_chunks.size() == N) begin
               longint unsigned w;
               w = 0;
               foreach (m_chunks[i]) w = w * 256 + longint'(m_chunks[i]);
               m_pout = PW'(w);
               m_chunks.delete();
               done = 1;
            end
         end
         if (done) m_valid = 1;
         else if (bus.POutAck) m_valid = 0;
      end
   end

   always @(negedge Clock) begin
      if (cmp_en) begin
         chk("POut",      bus.POut,      m_pout);
         chk("POutValid", bus.POutValid, m_valid);
         chk("Count",     bus.Count,     m_chunks.size());
         chk("SInReady",  bus.SInReady,  m_ready());
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic v, input logic [7:0] d, input logic c, input logic a);
      bus.SInValid = v;
      bus.SIn      = d;
      bus.Clear    = c;
      bus.POutAck  = a;
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic ack();
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic feed4(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) step(1'b1, w[i*8 +: 8], 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] w2;
      bus.SInValid = 0; bus.SIn = '0; bus.Clear = 0; bus.POutAck = 0;
      Reset = 1'b1;
      idle(); idle();
      Reset = 1'b0;
      cmp_en = 1;
      chk("rst_POut",      bus.POut, 32'h0);
      chk("rst_POutValid", bus.POutValid, 1'b0);
      chk("rst_Count",     bus.Count, 0);
      chk("rst_SInReady",  bus.SInReady, 1'b1);

      // Basic word and hold-until-ack
      feed4(32'hF9ABCDEF);
      chk("t1_POut",  bus.POut, 32'hF9ABCDEF);
      chk("t1_valid", bus.POutValid, 1'b1);
      chk("t1_count", bus.Count, 0);
      idle(); idle();
      chk("t1_stable", bus.POut, 32'hF9ABCDEF);
      ack();
      chk("t1_acked", bus.POutValid, 1'b0);

      // Back-to-back words, ack in the cycle each word appears
      w2 = 32'h55667788;
      feed4(32'h11223344);
      chk("t2_w1", bus.POut, 32'h11223344);
      for (int i = 3; i >= 0; i--) begin
         bus.SInValid = 1; bus.SIn = w2[i*8 +: 8]; bus.Clear = 0;
         bus.POutAck = (i == 3);
         #1;
         chk("t2_ready", bus.SInReady, 1'b1);
         @(posedge Clock); #1;
         if (i == 1) chk("t2_not_yet", bus.POut, 32'h11223344);
      end
      chk("t2_w2", bus.POut, 32'h55667788);
      chk("t2_valid", bus.POutValid, 1'b1);
      ack();

      // Stall on a completing chunk while word 1 is unconsumed
      feed4(32'hA1A2A3A4);
      step(1, 8'h55, 0, 0); step(1, 8'h66, 0, 0); step(1, 8'h77, 0, 0);
      bus.SInValid = 1; bus.SIn = 8'h88; bus.POutAck = 0; #1;
      chk("t3_stall_ready", bus.SInReady, 1'b0);
      chk("t3_stall_count", bus.Count, 3);
      @(posedge Clock); #1;
      chk("t3_held_POut", bus.POut, 32'hA1A2A3A4);
      chk("t3_held_count", bus.Count, 3);
      bus.POutAck = 1; #1;
      chk("t3_ack_ready", bus.SInReady, 1'b1);
      @(posedge Clock); #1;
      chk("t3_POut", bus.POut, 32'h55667788);
      chk("t3_valid", bus.POutValid, 1'b1);
      ack();

      // Clear drops the simultaneous chunk and the partial word
      step(1, 8'hAA, 0, 0); step(1, 8'hBB, 0, 0);
      step(1, 8'hCC, 1, 0);
      chk("t4_clr_count", bus.Count, 0);
      feed4(32'h01020304);
      chk("t4_POut", bus.POut, 32'h01020304);
      ack();

      // Gaps between chunks
      step(1, 8'hDE, 0, 0);
      idle();
      chk("t5_gap_count", bus.Count, 1);
      step(1, 8'hAD, 0, 0);
      idle(); idle();
      step(1, 8'hBE, 0, 0); step(1, 8'hEF, 0, 0);
      chk("t5_POut", bus.POut, 32'hDEADBEEF);

      // Mid-word reset while a word is valid
      step(1, 8'h99, 0, 0); step(1, 8'h98, 0, 0);
      Reset = 1'b1;
      idle();
      Reset = 1'b0;
      chk("t6_rst_valid", bus.POutValid, 1'b0);
      chk("t6_rst_count", bus.Count, 0);
      chk("t6_rst_POut",  bus.POut, 32'h0);
      feed4(32'h12345678);
      chk("t6_POut", bus.POut, 32'h12345678);

      // Clear together with an ack on a stalled completion
      step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0);
      step(1, 8'h04, 1, 1);
      chk("t7_clr_ack_valid", bus.POutValid, 1'b0);
      chk("t7_clr_ack_POut",  bus.POut, 32'h12345678);
      idle();

      cmp_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/chunk_deserializer.md
# chunk_deserializer

Serial-to-parallel collector: the receive-side counterpart of the parallel-load, chunk-serial ShiftRegister. It accepts a stream of swidth-bit chunks, most-significant chunk first, and reassembles each group of pwidth/swidth chunks into one pwidth-bit word. It sits at the far end of a chunk-serial link, for example board-state or shot words travelling between battleship game logic and the display/comms path. Each completed word is held in an output register under a valid/ack handshake, and backpressure is applied only when that register cannot be freed.

## Interface
- pwidth, 32, parallel output word width; must be an integer multiple of swidth.
- swidth, 8, chunk width; N = pwidth/swidth chunks per word, N ≥ 2.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state on the rising edge.
- SIn  in  swidth  incoming chunk.
- SInValid  in  1  SIn holds a chunk this cycle.
- SInReady  out  1  block accepts SIn this cycle (combinational).
- Clear  in  1  synchronous discard of any partially assembled word.
- POut  out  pwidth  last completed word, registered.
- POutValid  out  1  POut holds an unconsumed word.
- POutAck  in  1  consumer takes POut this cycle; ignored when POutValid=0.
- Count  out  clog2(N)  chunks accepted toward the current word (0..N-1).

## Operation
- Accept event: SInValid & SInReady & !Clear.
- Accumulator Acc is (pwidth-swidth) bits. On accept with Count<N-1:
  - Acc <= {Acc[pwidth-2*swidth-1:0], SIn}
  - Count <= Count+1
- On accept with Count=N-1 (completion):
  - POut <= {Acc, SIn}
  - POutValid <= 1
  - Count <= 0
  - Acc is don't-care but must be fully overwritten by the next word.
- Ordering: the first accepted chunk lands in POut[pwidth-1:pwidth-swidth]; the last lands in POut[swidth-1:0].
- SInReady = !(Count==N-1 & POutValid & !POutAck). Backpressure is applied only to a completing chunk that would overwrite an unconsumed word.
- POutValid next value:
  - 1 on completion, including when an ack occurs in the same cycle (the new word replaces the acked one).
  - 0 on POutAck without completion.
  - Otherwise held.
- POut changes only on completion. It is stable whenever POutValid=1 and no completion occurs.
- Clear: Count <= 0, Acc <= 0. Clear does not affect POut or POutValid, and still honours POutAck that cycle. Clear wins over a simultaneous chunk, which is dropped; SInReady may be high, but no accept occurs.
- SInValid=0 cycles (gaps) leave all state unchanged. Chunks need not be contiguous.
- Reset overrides everything, including a mid-word reset: Count, Acc and POut are 0, and POutValid is 0. SInReady=1 after reset.
- Parameter check: pwidth % swidth != 0 or N < 2 is a configuration error and must be flagged in elaboration/simulation.

## Timing
- Throughput: one chunk per cycle sustained, provided the consumer acks on or before the cycle the next word completes.
- Latency: POutValid and the new POut are visible the cycle after the Nth chunk is accepted.
- SInReady has a combinational path from POutAck. POut, POutValid and Count are registered outputs.
- Reset values: POut=0, POutValid=0, Count=0, SInReady=1 (Count=0 ≠ N-1).
- Count wraps N-1 → 0 on completion, with no idle cycle between words.
- A stalled completing chunk (SInReady=0) must be held by the sender. It is accepted in the first cycle that POutAck=1 or POutValid=0.

## Test plan
- Reset, then stream F9,AB,CD,EF on four consecutive cycles -> cycle 5: POut=32'hF9ABCDEF, POutValid=1, Count=0; POut stays stable until POutAck.
- Words 11223344 then 55667788 back-to-back, with POutAck asserted the cycle each word appears -> no SInReady deassertion; the second word appears exactly 4 cycles after the first.
- Word 1 unacked, then 55,66,77 followed by 88 held valid -> SInReady=0 on 88 with Count=3; POut=word 1 unchanged. Assert POutAck -> 88 accepted that cycle; next cycle POut=32'h55667788, POutValid=1.
- Chunks AA,BB, then Clear together with CC, then 01,02,03,04 -> CC dropped; POut=32'h01020304.
- Chunks with random SInValid gaps: DE,(gap),AD,(gap,gap),BE,EF -> POut=32'hDEADBEEF; Count advances only on accepts.
- Reset asserted after 2 chunks while POutValid=1 -> next cycle POutValid=0, Count=0, POut=0; the following 4 chunks 12,34,56,78 give POut=32'h12345678.
